// File: rtl/counter_timer_sched.sv
// ============================================================================
// counter_timer_sched : round-robin sharing of one loadable up-counter between
//                       two interval requesters. Rev 1.0
// ============================================================================
`default_nettype none

module counter_timer_sched #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] len0,
   input  logic [WIDTH-1:0] len1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             busy,
   output logic             cnt_en,
   output logic             cnt_ld,
   output logic             cnt_clr,
   output logic [WIDTH-1:0] cnt_dat,
   input  logic [WIDTH-1:0] cnt_q
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_owner;
   logic             r_prio;
   logic [WIDTH-1:0] r_len;

   logic w_pick;
   logic w_owner_req;
   logic w_at_len;

   // Tie goes to r_prio; otherwise whichever single requester is active.
   assign w_pick      = (req == 2'b11) ? r_prio : req[1];
   assign w_owner_req = req[r_owner];
   assign w_at_len    = (cnt_q == r_len);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         r_prio  <= 1'b0;
         r_len   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_owner <= w_pick;
                  r_len   <= w_pick ? len1 : len0;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               if (!w_owner_req) begin
                  r_prio  <= ~r_owner;
                  r_state <= IDLE;
               end else begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               // An abort wins over reaching the end of the interval.
               if (!w_owner_req) begin
                  r_prio  <= ~r_owner;
                  r_state <= IDLE;
               end else if (w_at_len) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_prio  <= ~r_owner;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy    = (r_state != IDLE);
   assign gnt     = {busy & r_owner, busy & ~r_owner};
   assign done    = {(r_state == DONE) & r_owner, (r_state == DONE) & ~r_owner};
   // Stopping the enable on the matching cycle leaves the counter holding r_len.
   assign cnt_en  = (r_state == LOAD) || ((r_state == RUN) && !w_at_len);
   assign cnt_ld  = (r_state == LOAD);
   assign cnt_clr = (r_state == IDLE);
   assign cnt_dat = '0;

endmodule

`default_nettype wire

// File: tb/tb_counter_timer_sched.sv
// ============================================================================
// tb_counter_timer_sched : directed bench for counter_timer_sched with a
//                          behavioural loadable up-counter attached. Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_timer_sched;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic [1:0]       req;
   logic [WIDTH-1:0] len0;
   logic [WIDTH-1:0] len1;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic             busy;
   logic             cnt_en;
   logic             cnt_ld;
   logic             cnt_clr;
   logic [WIDTH-1:0] cnt_dat;
   logic [WIDTH-1:0] cnt_q;

   int n_tests = 0;
   int n_fail  = 0;

   counter_timer_sched #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .len0    (len0),
      .len1    (len1),
      .gnt     (gnt),
      .done    (done),
      .busy    (busy),
      .cnt_en  (cnt_en),
      .cnt_ld  (cnt_ld),
      .cnt_clr (cnt_clr),
      .cnt_dat (cnt_dat),
      .cnt_q   (cnt_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The shared counter: synchronous clear, then load, then count.
   always_ff @(posedge clk) begin
      if (cnt_clr)     cnt_q <= '0;
      else if (cnt_ld) cnt_q <= cnt_dat;
      else if (cnt_en) cnt_q <= cnt_q + 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_gnt"},  32'(gnt),  32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_clr"},  32'(cnt_clr), 32'd1);
      check({tag, "_en"},   32'(cnt_en), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 2'b00;
      len0  = '0;
      len1  = '0;

      // ---------------- reset state ----------------
      tick();
      check_idle("rst");
      check("rst_ld",  32'(cnt_ld),  32'd0);
      check("rst_dat", 32'(cnt_dat), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check_idle("post_rst");

      // ---------------- single request, len0=3 ----------------
      req = 2'b01; len0 = 4'd3;                 // cycle 0
      check("t2_c0_busy", 32'(busy), 32'd0);
      tick();                                    // cycle 1: LOAD
      check("t2_load_gnt", 32'(gnt),    32'd1);
      check("t2_load_ld",  32'(cnt_ld), 32'd1);
      check("t2_load_en",  32'(cnt_en), 32'd1);
      check("t2_load_busy",32'(busy),   32'd1);
      check("t2_load_clr", 32'(cnt_clr),32'd0);
      len0 = 4'd9;                               // must be ignored after grant
      for (int k = 0; k <= 3; k++) begin        // cycles 2..5: RUN
         tick();
         check("t2_run_q",    32'(cnt_q),  32'(k));
         check("t2_run_en",   32'(cnt_en), (k == 3) ? 32'd0 : 32'd1);
         check("t2_run_gnt",  32'(gnt),    32'd1);
         check("t2_run_done", 32'(done),   32'd0);
      end
      tick();                                    // cycle 6: DONE
      check("t2_done",     32'(done),   32'd1);
      check("t2_done_gnt", 32'(gnt),    32'd1);
      check("t2_done_en",  32'(cnt_en), 32'd0);
      req = 2'b00;
      tick();                                    // cycle 7: IDLE, counter holds 3
      check_idle("t2_idle");
      check("t2_hold_q", 32'(cnt_q), 32'd3);
      tick();
      check("t2_clr_q",  32'(cnt_q), 32'd0);

      // ---------------- boundary len=0 ----------------
      req = 2'b01; len0 = 4'd0;
      tick();                                    // LOAD
      check("t4a_load_gnt", 32'(gnt), 32'd1);
      tick();                                    // RUN, already at length
      check("t4a_run_q",    32'(cnt_q),  32'd0);
      check("t4a_run_en",   32'(cnt_en), 32'd0);
      check("t4a_run_done", 32'(done),   32'd0);
      tick();                                    // t+3: DONE
      check("t4a_done", 32'(done), 32'd1);
      req = 2'b00;
      tick();
      check_idle("t4a_idle");

      // ---------------- boundary len=15, no wrap ----------------
      req = 2'b01; len0 = 4'd15;
      tick();                                    // cycle 1: LOAD
      for (int k = 0; k <= 15; k++) begin       // cycles 2..17
         tick();
         check("t4b_run_q",  32'(cnt_q),  32'(k));
         check("t4b_run_en", 32'(cnt_en), (k == 15) ? 32'd0 : 32'd1);
      end
      tick();                                    // cycle 18: DONE
      check("t4b_done",   32'(done),  32'd1);
      check("t4b_done_q", 32'(cnt_q), 32'd15);
      req = 2'b00;
      tick();
      check_idle("t4b_idle");
      check("t4b_hold_q", 32'(cnt_q), 32'd15);

      // ---------------- hold: req0 kept high, then tie after req0 served ----------------
      req = 2'b01; len0 = 4'd1;
      tick();                                    // LOAD
      check("t6_load_gnt", 32'(gnt), 32'd1);
      tick();                                    // RUN q=0
      tick();                                    // RUN q=1
      check("t6_run_en", 32'(cnt_en), 32'd0);
      tick();                                    // DONE
      check("t6_done", 32'(done), 32'd1);
      tick();                                    // IDLE, req0 still high
      check_idle("t6_idle");
      tick();                                    // regranted
      check("t6_regrant_gnt", 32'(gnt),    32'd1);
      check("t6_regrant_ld",  32'(cnt_ld), 32'd1);
      req = 2'b11; len1 = 4'd2;                 // req1 waits while busy
      tick();                                    // RUN q=0
      check("t6_wait_gnt", 32'(gnt), 32'd1);
      tick();                                    // RUN q=1
      tick();                                    // DONE for req0
      check("t6_done2", 32'(done), 32'd1);
      tick();                                    // IDLE
      check_idle("t6_idle2");
      tick();                                    // tie after req0 served: req1 wins
      check("t6_tie_gnt", 32'(gnt), 32'd2);
      tick();                                    // RUN q=0
      tick();                                    // RUN q=1
      tick();                                    // RUN q=2
      check("t6_r1_q",  32'(cnt_q),  32'd2);
      check("t6_r1_en", 32'(cnt_en), 32'd0);
      tick();                                    // DONE for req1
      check("t6_r1_done", 32'(done), 32'd2);
      req = 2'b00;
      tick();
      check_idle("t6_idle3");

      // ---------------- abort ----------------
      req = 2'b01; len0 = 4'd10;
      tick();                                    // LOAD
      check("t5_load_gnt", 32'(gnt), 32'd1);
      req = 2'b11; len1 = 4'd2;
      for (int k = 0; k <= 4; k++) begin        // RUN q=0..4
         tick();
         check("t5_run_q",    32'(cnt_q), 32'(k));
         check("t5_run_done", 32'(done),  32'd0);
      end
      req = 2'b10;                               // drop req0 at q=4
      tick();                                    // IDLE, no done
      check_idle("t5_abort");
      tick();                                    // pending req1 granted
      check("t5_r1_gnt", 32'(gnt),    32'd2);
      check("t5_r1_ld",  32'(cnt_ld), 32'd1);
      tick();                                    // RUN q=0
      check("t5_r1_q0", 32'(cnt_q), 32'd0);
      tick();                                    // RUN q=1
      tick();                                    // RUN q=2
      tick();                                    // DONE
      check("t5_r1_done", 32'(done), 32'd2);
      req = 2'b11; len0 = 4'd1;
      tick();                                    // IDLE
      check_idle("t5_idle");
      tick();                                    // tie now goes to req0
      check("t5_tie_gnt", 32'(gnt), 32'd1);
      tick();                                    // RUN q=0
      tick();                                    // RUN q=1
      tick();                                    // DONE
      check("t5_r0_done", 32'(done), 32'd1);
      req = 2'b00;
      tick();
      check_idle("t5_idle2");

      // ---------------- reset mid-RUN ----------------
      req = 2'b01; len0 = 4'd15;
      tick();                                    // LOAD
      tick();                                    // RUN q=0
      tick();                                    // RUN q=1
      check("t1_pre_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_idle("t1_async");
      check("t1_ld", 32'(cnt_ld), 32'd0);

      // ---------------- tie from reset ----------------
      req = 2'b11; len0 = 4'd2; len1 = 4'd5;
      tick();
      tick();
      check_idle("t3_in_rst");
      check("t3_rst_q", 32'(cnt_q), 32'd0);
      rst_n = 1'b1;                              // cycle 0
      tick();                                    // cycle 1: LOAD for req0
      check("t3_g0", 32'(gnt), 32'd1);
      tick();                                    // cycle 2
      tick();                                    // cycle 3
      tick();                                    // cycle 4: q=2
      check("t3_r0_q",  32'(cnt_q),  32'd2);
      check("t3_r0_en", 32'(cnt_en), 32'd0);
      tick();                                    // cycle 5: DONE req0
      check("t3_done0", 32'(done), 32'd1);
      req = 2'b10;
      tick();                                    // cycle 6: IDLE, grant req1
      check_idle("t3_idle");
      tick();                                    // cycle 7: LOAD req1
      check("t3_g1", 32'(gnt), 32'd2);
      for (int k = 0; k <= 5; k++) begin        // cycles 8..13
         tick();
         check("t3_r1_q",    32'(cnt_q), 32'(k));
         check("t3_r1_done", 32'(done),  32'd0);
      end
      tick();                                    // cycle 14: DONE req1
      check("t3_done1", 32'(done), 32'd2);
      req = 2'b00;
      tick();
      check_idle("t3_end");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
